// File: rtl/axi_lite_slave_regs.sv
// AXI4-Lite slave with CTRL/ADDR_LO/ADDR_HI registers and a read-only STATUS word. Byte-lane masking is enabled by AXI_REGS_WSTRB_EN.
// Latency: readies pulse one cycle after the request is seen; BVALID/RVALID follow the handshake by one cycle.
// Backpressure: a single write and a single read may be outstanding; new requests wait until BREADY/RREADY retire the response.
module axi_lite_slave_regs #(
    parameter int C_S_AXI_DATA_WIDTH = 32,
    parameter int C_S_AXI_ADDR_WIDTH = 4
) (
    input  logic                            s_axi_aclk,
    input  logic                            s_axi_aresetn,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]   s_axi_awaddr,
    input  logic [2:0]                      s_axi_awprot,
    input  logic                            s_axi_awvalid,
    output logic                            s_axi_awready,
    input  logic [C_S_AXI_DATA_WIDTH-1:0]   s_axi_wdata,
    input  logic [C_S_AXI_DATA_WIDTH/8-1:0] s_axi_wstrb,
    input  logic                            s_axi_wvalid,
    output logic                            s_axi_wready,
    output logic [1:0]                      s_axi_bresp,
    output logic                            s_axi_bvalid,
    input  logic                            s_axi_bready,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]   s_axi_araddr,
    input  logic [2:0]                      s_axi_arprot,
    input  logic                            s_axi_arvalid,
    output logic                            s_axi_arready,
    output logic [C_S_AXI_DATA_WIDTH-1:0]   s_axi_rdata,
    output logic [1:0]                      s_axi_rresp,
    output logic                            s_axi_rvalid,
    input  logic                            s_axi_rready,
    output logic [C_S_AXI_DATA_WIDTH-1:0]   ctrl_out,
    output logic [C_S_AXI_DATA_WIDTH-1:0]   addr_lo_out,
    output logic [C_S_AXI_DATA_WIDTH-1:0]   addr_hi_out,
    input  logic [C_S_AXI_DATA_WIDTH-1:0]   status_in
);

    localparam int NB = C_S_AXI_DATA_WIDTH / 8;
    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] IDX_STATUS  = 2'd3;

    typedef enum logic [1:0] {
        W_IDLE,
        W_ACK,
        W_RESP
    } wr_state_t;

    typedef enum logic [1:0] {
        R_IDLE,
        R_ACK,
        R_DATA
    } rd_state_t;

    wr_state_t wr_state_q, wr_state_d;
    rd_state_t rd_state_q, rd_state_d;

    logic [C_S_AXI_DATA_WIDTH-1:0] ctrl_q, ctrl_d;
    logic [C_S_AXI_DATA_WIDTH-1:0] addr_lo_q, addr_lo_d;
    logic [C_S_AXI_DATA_WIDTH-1:0] addr_hi_q, addr_hi_d;
    logic [C_S_AXI_DATA_WIDTH-1:0] rdata_q, rdata_d;
    logic [1:0]                    bresp_q, bresp_d;

    logic                          wr_hs;
    logic                          rd_hs;
    logic [1:0]                    wr_idx;
    logic [1:0]                    rd_idx;
    logic [C_S_AXI_DATA_WIDTH-1:0] wr_mask;
    logic [C_S_AXI_DATA_WIDTH-1:0] rd_word;
    logic                          unused_ok;

    assign wr_idx = s_axi_awaddr[3:2];
    assign rd_idx = s_axi_araddr[3:2];

    // Protection bits and sub-word address bits carry no meaning for this block.
    assign unused_ok = ^{s_axi_awprot, s_axi_arprot, s_axi_awaddr, s_axi_araddr, s_axi_wstrb};

    // Write channel: address and data are only taken together, one write in flight.
    always_comb begin
        wr_state_d = wr_state_q;
        wr_hs      = 1'b0;
        case (wr_state_q)
            W_IDLE: begin
                if (s_axi_awvalid && s_axi_wvalid) begin
                    wr_state_d = W_ACK;
                end
            end
            W_ACK: begin
                if (s_axi_awvalid && s_axi_wvalid) begin
                    wr_hs      = 1'b1;
                    wr_state_d = W_RESP;
                end else begin
                    wr_state_d = W_IDLE;
                end
            end
            W_RESP: begin
                if (s_axi_bready) begin
                    wr_state_d = W_IDLE;
                end
            end
            default: wr_state_d = W_IDLE;
        endcase
    end

    always_comb begin
        rd_state_d = rd_state_q;
        rd_hs      = 1'b0;
        case (rd_state_q)
            R_IDLE: begin
                if (s_axi_arvalid) begin
                    rd_state_d = R_ACK;
                end
            end
            R_ACK: begin
                if (s_axi_arvalid) begin
                    rd_hs      = 1'b1;
                    rd_state_d = R_DATA;
                end else begin
                    rd_state_d = R_IDLE;
                end
            end
            R_DATA: begin
                if (s_axi_rready) begin
                    rd_state_d = R_IDLE;
                end
            end
            default: rd_state_d = R_IDLE;
        endcase
    end

`ifdef AXI_REGS_WSTRB_EN
    always_comb begin
        wr_mask = '0;
        for (int i = 0; i < NB; i++) begin
            wr_mask[i*8 +: 8] = {8{s_axi_wstrb[i]}};
        end
    end
`else
    assign wr_mask = '1;
`endif

    always_comb begin
        ctrl_d    = ctrl_q;
        addr_lo_d = addr_lo_q;
        addr_hi_d = addr_hi_q;
        bresp_d   = bresp_q;
        if (wr_hs) begin
            bresp_d = (wr_idx == IDX_STATUS) ? RESP_SLVERR : RESP_OKAY;
            case (wr_idx)
                2'd0:    ctrl_d    = (ctrl_q    & ~wr_mask) | (s_axi_wdata & wr_mask);
                2'd1:    addr_lo_d = (addr_lo_q & ~wr_mask) | (s_axi_wdata & wr_mask);
                2'd2:    addr_hi_d = (addr_hi_q & ~wr_mask) | (s_axi_wdata & wr_mask);
                default: ;
            endcase
        end
    end

    // Sampled from the pre-write register values, so a same-edge write is not visible.
    always_comb begin
        rd_word = '0;
        case (rd_idx)
            2'd0:    rd_word = ctrl_q;
            2'd1:    rd_word = addr_lo_q;
            2'd2:    rd_word = addr_hi_q;
            default: rd_word = status_in;
        endcase
    end

    always_comb begin
        rdata_d = rdata_q;
        if (rd_hs) begin
            rdata_d = rd_word;
        end
    end

    always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn) begin
        if (!s_axi_aresetn) begin
            wr_state_q <= W_IDLE;
            rd_state_q <= R_IDLE;
            ctrl_q     <= '0;
            addr_lo_q  <= '0;
            addr_hi_q  <= '0;
            rdata_q    <= '0;
            bresp_q    <= RESP_OKAY;
        end else begin
            wr_state_q <= wr_state_d;
            rd_state_q <= rd_state_d;
            ctrl_q     <= ctrl_d;
            addr_lo_q  <= addr_lo_d;
            addr_hi_q  <= addr_hi_d;
            rdata_q    <= rdata_d;
            bresp_q    <= bresp_d;
        end
    end

    assign s_axi_awready = (wr_state_q == W_ACK);
    assign s_axi_wready  = (wr_state_q == W_ACK);
    assign s_axi_bvalid  = (wr_state_q == W_RESP);
    assign s_axi_bresp   = bresp_q;
    assign s_axi_arready = (rd_state_q == R_ACK);
    assign s_axi_rvalid  = (rd_state_q == R_DATA);
    assign s_axi_rdata   = rdata_q;
    assign s_axi_rresp   = RESP_OKAY;

    assign ctrl_out    = ctrl_q;
    assign addr_lo_out = addr_lo_q;
    assign addr_hi_out = addr_hi_q;

endmodule

// File: tb/tb_axi_lite_slave_regs.sv
// Randomized self-checking bench for axi_lite_slave_regs against an array-based register model.
`timescale 1ns/1ps
module tb_axi_lite_slave_regs;

    logic        clk = 1'b0;
    logic        aresetn;
    logic [3:0]  awaddr;
    logic [2:0]  awprot;
    logic        awvalid;
    logic        awready;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        wvalid;
    logic        wready;
    logic [1:0]  bresp;
    logic        bvalid;
    logic        bready;
    logic [3:0]  araddr;
    logic [2:0]  arprot;
    logic        arvalid;
    logic        arready;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic        rvalid;
    logic        rready;
    logic [31:0] ctrl_out;
    logic [31:0] addr_lo_out;
    logic [31:0] addr_hi_out;
    logic [31:0] status_in;

    int total = 0;
    int bad   = 0;

    logic [31:0] model [0:3];

    always #5 clk = ~clk;

    axi_lite_slave_regs #(
        .C_S_AXI_DATA_WIDTH(32),
        .C_S_AXI_ADDR_WIDTH(4)
    ) dut (
        .s_axi_aclk   (clk),
        .s_axi_aresetn(aresetn),
        .s_axi_awaddr (awaddr),
        .s_axi_awprot (awprot),
        .s_axi_awvalid(awvalid),
        .s_axi_awready(awready),
        .s_axi_wdata  (wdata),
        .s_axi_wstrb  (wstrb),
        .s_axi_wvalid (wvalid),
        .s_axi_wready (wready),
        .s_axi_bresp  (bresp),
        .s_axi_bvalid (bvalid),
        .s_axi_bready (bready),
        .s_axi_araddr (araddr),
        .s_axi_arprot (arprot),
        .s_axi_arvalid(arvalid),
        .s_axi_arready(arready),
        .s_axi_rdata  (rdata),
        .s_axi_rresp  (rresp),
        .s_axi_rvalid (rvalid),
        .s_axi_rready (rready),
        .ctrl_out     (ctrl_out),
        .addr_lo_out  (addr_lo_out),
        .addr_hi_out  (addr_hi_out),
        .status_in    (status_in)
    );

    // Reference: word index from the byte address, STATUS is read-only.
    function automatic logic [1:0] model_write(input logic [3:0] addr, input logic [31:0] data,
                                               input logic [3:0] strb);
        int idx;
        logic [3:0] en;
        idx = int'(addr[3:2]);
`ifdef AXI_REGS_WSTRB_EN
        en = strb;
`else
        en = strb | 4'hF;
`endif
        if (idx == 3) return 2'b10;
        for (int b = 0; b < 4; b++) begin
            if (en[b]) model[idx][b*8 +: 8] = data[b*8 +: 8];
        end
        return 2'b00;
    endfunction

    function automatic logic [31:0] model_read(input logic [3:0] addr);
        int idx;
        idx = int'(addr[3:2]);
        if (idx == 3) return status_in;
        return model[idx];
    endfunction

    task automatic axi_write(input logic [3:0] addr, input logic [31:0] data, input logic [3:0] strb,
                             output logic [1:0] resp, output logic bseen, output int rdy_cycles,
                             output logic tmo);
        int n;
        awaddr = addr; wdata = data; wstrb = strb; awprot = 3'($urandom_range(0, 7));
        awvalid = 1'b1; wvalid = 1'b1; bready = 1'b1;
        tmo = 1'b0; n = 0; resp = 2'b00; bseen = 1'b0; rdy_cycles = 0;
        do begin
            @(posedge clk); #1; n++;
        end while (!(awready && wready) && n < 20);
        if (!(awready && wready)) begin
            tmo = 1'b1; awvalid = 1'b0; wvalid = 1'b0;
            return;
        end
        rdy_cycles = 1;
        @(posedge clk); #1;
        awvalid = 1'b0; wvalid = 1'b0;
        if (awready || wready) rdy_cycles++;
        bseen = bvalid;
        resp  = bresp;
        @(posedge clk); #1;
    endtask

    task automatic axi_read(input logic [3:0] addr, output logic [31:0] data, output logic [1:0] resp,
                            output logic rseen, output logic tmo);
        int n;
        araddr = addr; arprot = 3'($urandom_range(0, 7));
        arvalid = 1'b1; rready = 1'b1;
        tmo = 1'b0; n = 0; data = '0; resp = 2'b00; rseen = 1'b0;
        do begin
            @(posedge clk); #1; n++;
        end while (!arready && n < 20);
        if (!arready) begin
            tmo = 1'b1; arvalid = 1'b0;
            return;
        end
        @(posedge clk); #1;
        arvalid = 1'b0;
        rseen = rvalid;
        data  = rdata;
        resp  = rresp;
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        logic [7:0] hs;
        aresetn = 1'b0;
        #23;
        hs = {awready, wready, bvalid, arready, rvalid, 1'b0, bresp, rresp} ;
        total++;
        if (hs !== 8'h00) begin
            bad++; $display("FAIL reset_handshake: got %h want 00", hs);
        end
        total++;
        if (rdata !== 32'h0) begin
            bad++; $display("FAIL reset_rdata: got %h want 0", rdata);
        end
        total++;
        if ({ctrl_out, addr_lo_out, addr_hi_out} !== 96'h0) begin
            bad++; $display("FAIL reset_regs: got %h %h %h want 0", ctrl_out, addr_lo_out, addr_hi_out);
        end
        for (int i = 0; i < 4; i++) model[i] = '0;
        @(negedge clk); aresetn = 1'b1;
    endtask

    task automatic test_write_basic();
        logic [1:0] resp; logic bs; int rc; logic tmo; logic [1:0] er;
        er = model_write(4'h8, 32'h0000_1000, 4'hF);
        axi_write(4'h8, 32'h0000_1000, 4'hF, resp, bs, rc, tmo);
        total++;
        if (tmo || rc != 1 || !bs) begin
            bad++; $display("FAIL wr_basic_handshake: tmo=%0d ready_cycles=%0d bvalid=%0d want 0/1/1", tmo, rc, bs);
        end
        total++;
        if (resp !== er) begin
            bad++; $display("FAIL wr_basic_bresp: got %b want %b", resp, er);
        end
        total++;
        if (addr_hi_out !== model[2]) begin
            bad++; $display("FAIL wr_basic_addr_hi: got %h want %h", addr_hi_out, model[2]);
        end
        total++;
        if (bvalid !== 1'b0) begin
            bad++; $display("FAIL wr_basic_bclear: bvalid=%b want 0", bvalid);
        end
    endtask

    task automatic test_aw_before_w();
        logic [31:0] d; logic [1:0] er; int n;
        d = $urandom;
        awaddr = 4'h4; wdata = d; wstrb = 4'hF; bready = 1'b1;
        awvalid = 1'b1; wvalid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            total++;
            if (awready || wready) begin
                bad++; $display("FAIL aw_only_wait: cycle %0d awready=%b wready=%b want 0", i, awready, wready);
            end
        end
        wvalid = 1'b1;
        n = 0;
        do begin
            @(posedge clk); #1; n++;
        end while (!(awready && wready) && n < 20);
        total++;
        if (n != 1 || !(awready && wready)) begin
            bad++; $display("FAIL aw_w_accept: ready after %0d cycles want 1", n);
        end
        @(posedge clk); #1;
        awvalid = 1'b0; wvalid = 1'b0;
        er = model_write(4'h4, d, 4'hF);
        total++;
        if (awready || wready || !bvalid || bresp !== er) begin
            bad++; $display("FAIL aw_w_single: awready=%b wready=%b bvalid=%b bresp=%b want 0 0 1 %b",
                            awready, wready, bvalid, bresp, er);
        end
        total++;
        if (addr_lo_out !== model[1]) begin
            bad++; $display("FAIL aw_w_addr_lo: got %h want %h", addr_lo_out, model[1]);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_status_slverr();
        logic [1:0] resp; logic bs; int rc; logic tmo; logic [31:0] d; logic rs; logic [1:0] er;
        status_in = 32'hA5A5_0001;
        er = model_write(4'hC, 32'hFFFF_FFFF, 4'hF);
        axi_write(4'hC, 32'hFFFF_FFFF, 4'hF, resp, bs, rc, tmo);
        total++;
        if (tmo || !bs || resp !== er) begin
            bad++; $display("FAIL status_write_bresp: got %b (tmo=%0d) want %b", resp, tmo, er);
        end
        total++;
        if ({ctrl_out, addr_lo_out, addr_hi_out} !== {model[0], model[1], model[2]}) begin
            bad++; $display("FAIL status_write_nochange: got %h %h %h want %h %h %h",
                            ctrl_out, addr_lo_out, addr_hi_out, model[0], model[1], model[2]);
        end
        axi_read(4'hC, d, resp, rs, tmo);
        total++;
        if (tmo || !rs || d !== 32'hA5A5_0001 || resp !== 2'b00) begin
            bad++; $display("FAIL status_read: got %h resp %b want a5a50001 resp 00", d, resp);
        end
    endtask

    task automatic test_read_stall();
        logic [31:0] held; logic [31:0] exp; int n;
        exp = model_read(4'h0);
        araddr = 4'h1; arvalid = 1'b1; rready = 1'b0;
        n = 0;
        do begin
            @(posedge clk); #1; n++;
        end while (!arready && n < 20);
        @(posedge clk); #1;
        held = rdata;
        total++;
        if (!rvalid || held !== exp) begin
            bad++; $display("FAIL stall_first: rvalid=%b rdata=%h want 1 %h", rvalid, held, exp);
        end
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            total++;
            if (!rvalid || rdata !== held || arready) begin
                bad++; $display("FAIL stall_hold: cycle %0d rvalid=%b rdata=%h arready=%b want 1 %h 0",
                                i, rvalid, rdata, arready, held);
            end
        end
        rready = 1'b1;
        @(posedge clk); #1;
        total++;
        if (rvalid || arready) begin
            bad++; $display("FAIL stall_release: rvalid=%b arready=%b want 0 0", rvalid, arready);
        end
        @(posedge clk); #1;
        total++;
        if (!arready) begin
            bad++; $display("FAIL stall_second_accept: arready=%b want 1", arready);
        end
        @(posedge clk); #1;
        arvalid = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_wstrb();
        logic [1:0] resp; logic bs; int rc; logic tmo; logic [1:0] er; logic [31:0] want;
        er = model_write(4'h0, 32'h1122_3344, 4'hF);
        axi_write(4'h0, 32'h1122_3344, 4'hF, resp, bs, rc, tmo);
        er = model_write(4'h0, 32'hAABB_CCDD, 4'h3);
        axi_write(4'h0, 32'hAABB_CCDD, 4'h3, resp, bs, rc, tmo);
`ifdef AXI_REGS_WSTRB_EN
        want = 32'h1122_CCDD;
`else
        want = 32'hAABB_CCDD;
`endif
        total++;
        if (tmo || resp !== er || ctrl_out !== want) begin
            bad++; $display("FAIL wstrb_ctrl: got %h resp %b want %h resp %b", ctrl_out, resp, want, er);
        end
    endtask

    task automatic test_simultaneous();
        logic [31:0] old; logic [31:0] nw; logic [1:0] er;
        old = model_read(4'h4);
        nw = $urandom;
        awaddr = 4'h4; wdata = nw; wstrb = 4'hF; araddr = 4'h4;
        bready = 1'b1; rready = 1'b1;
        awvalid = 1'b1; wvalid = 1'b1; arvalid = 1'b1;
        @(posedge clk); #1;
        total++;
        if (!(awready && wready && arready)) begin
            bad++; $display("FAIL sim_ready: awready=%b wready=%b arready=%b want 1 1 1", awready, wready, arready);
        end
        @(posedge clk); #1;
        awvalid = 1'b0; wvalid = 1'b0; arvalid = 1'b0;
        er = model_write(4'h4, nw, 4'hF);
        total++;
        if (!rvalid || rdata !== old) begin
            bad++; $display("FAIL sim_read_old: rvalid=%b rdata=%h want 1 %h", rvalid, rdata, old);
        end
        total++;
        if (!bvalid || bresp !== er || addr_lo_out !== model[1]) begin
            bad++; $display("FAIL sim_write_new: bvalid=%b addr_lo=%h want 1 %h", bvalid, addr_lo_out, model[1]);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_random();
        logic [1:0] resp; logic seen; int rc; logic tmo; logic [1:0] er;
        logic [3:0] a; logic [31:0] d; logic [3:0] s; logic [31:0] exp;
        for (int i = 0; i < 60; i++) begin
            a = 4'($urandom_range(0, 15));
            d = $urandom;
            s = 4'($urandom_range(0, 15));
            status_in = $urandom;
            if ($urandom_range(0, 1) == 1) begin
                er = model_write(a, d, s);
                axi_write(a, d, s, resp, seen, rc, tmo);
                total++;
                if (tmo || !seen || rc != 1 || resp !== er) begin
                    bad++; $display("FAIL rand_write %0d: addr %h resp %b tmo %0d want resp %b", i, a, resp, tmo, er);
                end
                total++;
                if ({ctrl_out, addr_lo_out, addr_hi_out} !== {model[0], model[1], model[2]}) begin
                    bad++; $display("FAIL rand_regs %0d: got %h %h %h want %h %h %h", i,
                                    ctrl_out, addr_lo_out, addr_hi_out, model[0], model[1], model[2]);
                end
            end else begin
                exp = model_read(a);
                axi_read(a, d, resp, seen, tmo);
                total++;
                if (tmo || !seen || d !== exp || resp !== 2'b00) begin
                    bad++; $display("FAIL rand_read %0d: addr %h got %h resp %b want %h resp 00", i, a, d, resp, exp);
                end
            end
            repeat ($urandom_range(0, 2)) @(posedge clk);
            #1;
        end
    endtask

    task automatic test_reset_mid();
        logic [31:0] d; logic [1:0] resp; logic rs; logic tmo; int n;
        awaddr = 4'h0; wdata = 32'hDEAD_BEEF; wstrb = 4'hF; bready = 1'b0;
        awvalid = 1'b1; wvalid = 1'b1;
        n = 0;
        do begin
            @(posedge clk); #1; n++;
        end while (!awready && n < 20);
        @(posedge clk); #1;
        awvalid = 1'b0; wvalid = 1'b0;
        total++;
        if (!bvalid) begin
            bad++; $display("FAIL rst_mid_pending: bvalid=%b want 1", bvalid);
        end
        #2 aresetn = 1'b0;
        #1;
        for (int i = 0; i < 4; i++) model[i] = '0;
        total++;
        if (bvalid || {ctrl_out, addr_lo_out, addr_hi_out} !== 96'h0) begin
            bad++; $display("FAIL rst_mid_immediate: bvalid=%b regs %h %h %h want 0", bvalid,
                            ctrl_out, addr_lo_out, addr_hi_out);
        end
        @(negedge clk); aresetn = 1'b1; bready = 1'b1;
        for (int r = 0; r < 3; r++) begin
            axi_read(4'(r * 4), d, resp, rs, tmo);
            total++;
            if (tmo || !rs || d !== model[r]) begin
                bad++; $display("FAIL rst_mid_readback %0d: got %h want %h", r, d, model[r]);
            end
        end
    endtask

    initial begin
        aresetn = 1'b0;
        awaddr = '0; awprot = '0; awvalid = 1'b0; wdata = '0; wstrb = '0; wvalid = 1'b0; bready = 1'b1;
        araddr = '0; arprot = '0; arvalid = 1'b0; rready = 1'b1; status_in = '0;
        test_reset();
        test_write_basic();
        test_aw_before_w();
        test_status_slverr();
        test_read_stall();
        test_wstrb();
        test_simultaneous();
        test_random();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/axi_lite_slave_regs.md
AXI_LITE_SLAVE_REGS -- requirements
Module: axi_lite_slave_regs

Interface
REQ-001 The block SHALL have parameter C_S_AXI_DATA_WIDTH, default 32, giving the data bus width (only 32 supported).
REQ-002 The block SHALL have parameter C_S_AXI_ADDR_WIDTH, default 4, giving the byte address width (4 words).
REQ-003 The block SHALL have port s_axi_aclk, input, 1 bit: the single clock; all logic on the rising edge.
REQ-004 The block SHALL have port s_axi_aresetn, input, 1 bit: asynchronous, active-low reset.
REQ-005 The block SHALL have port s_axi_awaddr, input, C_S_AXI_ADDR_WIDTH bits: write address.
REQ-006 The block SHALL have port s_axi_awprot, input, 3 bits: write protection, ignored.
REQ-007 The block SHALL have port s_axi_awvalid, input, 1 bit; and port s_axi_awready, output, 1 bit.
REQ-008 The block SHALL have port s_axi_wdata, input, 32 bits; and port s_axi_wstrb, input, 4 bits: byte strobes.
REQ-009 The block SHALL have port s_axi_wvalid, input, 1 bit; and port s_axi_wready, output, 1 bit.
REQ-010 The block SHALL have port s_axi_bresp, output, 2 bits; s_axi_bvalid, output, 1 bit; and s_axi_bready, input, 1 bit.
REQ-011 The block SHALL have port s_axi_araddr, input, C_S_AXI_ADDR_WIDTH bits; and s_axi_arprot, input, 3 bits, ignored.
REQ-012 The block SHALL have port s_axi_arvalid, input, 1 bit; and port s_axi_arready, output, 1 bit.
REQ-013 The block SHALL have port s_axi_rdata, output, 32 bits; s_axi_rresp, output, 2 bits; s_axi_rvalid, output, 1 bit; and s_axi_rready, input, 1 bit.
REQ-014 The block SHALL have port ctrl_out, output, 32 bits: the CTRL register (offset 0x0).
REQ-015 The block SHALL have port addr_lo_out, output, 32 bits: the ADDR_LO register (offset 0x4), the lower instruction-address bound.
REQ-016 The block SHALL have port addr_hi_out, output, 32 bits: the ADDR_HI register (offset 0x8), the upper instruction-address bound.
REQ-017 The block SHALL have port status_in, input, 32 bits: read-only STATUS (offset 0xC), sampled at read-address handshake.

Function
REQ-018 The block SHALL decode the register by addr[3:2]; addr[1:0] are ignored.
REQ-019 Write accept: when awvalid=1, wvalid=1, awready=0 and bvalid=0, the block SHALL pulse awready and wready together for exactly one cycle on the next cycle.
REQ-020 On that handshake edge the block SHALL update the addressed register, then assert bvalid on the following cycle.
REQ-021 The block SHALL hold bvalid and bresp stable until bready=1, and clear bvalid on the edge where bvalid&&bready.
REQ-022 The block SHALL accept no new write while bvalid=1; awready/wready stay 0.
REQ-023 If only one of awvalid/wvalid is high, the block SHALL wait without asserting either ready.
REQ-024 bresp SHALL be OKAY (2'b00) for offsets 0x0-0x8; for a write to 0xC it SHALL be SLVERR (2'b10), with no state change.
REQ-025 Read accept: when arvalid=1, arready=0 and rvalid=0, the block SHALL pulse arready for one cycle on the next cycle and latch rdata on that edge.
REQ-026 The block SHALL assert rvalid the cycle after the arready pulse and hold rvalid and rdata stable until rready=1; rresp SHALL always be OKAY.
REQ-027 The read and write channels SHALL be independent; a read whose arready handshake coincides with a write handshake to the same register SHALL return the old value.
REQ-028 ctrl_out, addr_lo_out and addr_hi_out SHALL reflect the new value the cycle after the write handshake.

Reset
REQ-029 While s_axi_aresetn=0, independent of the clock, the block SHALL drive awready, wready, bvalid, arready and rvalid to 0, bresp, rresp and rdata to 0, and CTRL, ADDR_LO and ADDR_HI to 0.
REQ-030 Reset mid-transaction SHALL abort it: pending bvalid/rvalid are dropped and no partial write survives.

Configuration
REQ-031 With AXI_REGS_WSTRB_EN defined, the block SHALL update byte lane i only when wstrb[i]=1; without it, wstrb SHALL be ignored and the full 32-bit word written.

Verification
REQ-032 Scenario: write 0x8 data 0x0000_1000, wstrb 0xF, bready=1 -> awready/wready pulse once, bvalid next cycle with bresp 00, and addr_hi_out=0x0000_1000.
REQ-033 Scenario: awvalid held 3 cycles before wvalid -> no ready during those cycles, single handshake after wvalid rises.
REQ-034 Scenario: write 0xC data 0xFFFF_FFFF -> bresp 10; then read 0xC with status_in=0xA5A5_0001 -> rdata 0xA5A5_0001, rresp 00.
REQ-035 Scenario: read 0x0 with rready held 0 for 5 cycles -> rvalid and rdata stable throughout, and a second arvalid is not accepted until rready=1.
REQ-036 Scenario: with AXI_REGS_WSTRB_EN defined, CTRL=0x1122_3344, write 0xAABB_CCDD with wstrb 0x3 -> ctrl_out=0x1122_CCDD; without the macro -> 0xAABB_CCDD.
REQ-037 Scenario: assert reset while bvalid=1 and bready=0 -> bvalid=0 immediately, all registers read 0 after release.
